week0303_mag_comparator: RTL and testbench
==========================================

Name: week0303_mag_comparator

Overview:
- Registered magnitude comparator: compares operands A and B and drives one-hot Eq/Gt/Lt flags one clock after a qualified input.
- Built from chained 4-bit cascadable slices, so width scales in 4-bit steps; default instance is the 4-bit comparator used in the week-3 datapath.
- Supports unsigned and two's-complement signed comparison.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of 4 and at least 4; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies A, B, signed_mode this cycle
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement signed compare
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  result flags updated this cycle
- Eq  output  1  A == B
- Gt  output  1  A > B
- Lt  output  1  A < B

Behaviour:
- Interface: one clock domain, clk; reset asynchronous, active-low, rst_n.
- Reset, asserted asynchronously: out_valid=0, Eq=0, Gt=0, Lt=0. Release is synchronous to the next clk edge (standard reset synchroniser outside the block).
- Latency: exactly 1 cycle. A sample with in_valid=1 at edge N produces out_valid=1 and flags after edge N+1.
- Throughput: one compare per cycle, back-to-back, no stall or backpressure.
- in_valid=0 at an edge: out_valid=0 next cycle. Eq/Gt/Lt hold their last values; the bench must not check them while out_valid=0.
- When out_valid=1, exactly one of Eq/Gt/Lt is 1.
- Unsigned mode: plain magnitude compare of A and B.
- Signed mode: compare as two's complement. Implemented by inverting the MSB of both operands before the slice chain; Eq is unaffected.
- Slice chaining:
  - Most-significant slice decides first.
  - Each slice takes cascade inputs (eq_i, gt_i, lt_i) from the next-more-significant slice.
  - If the upstream slice is not equal, its result passes through unchanged.
  - Otherwise the slice's own 4-bit compare decides.
  - Top-level cascade seed: eq_i=1, gt_i=0, lt_i=0.
- Combinational path A/B to flag register: WIDTH/4 slice levels, no feedback.
- rst_n asserted mid-stream: the pending result is discarded; the first out_valid after release belongs to the first in_valid sampled after release.
- X/Z on inputs while in_valid=0 must not propagate into the flag registers.

Decomposition:
- Shared package week03_pkg:
  - localparam SLICE_W = 4.
  - Typedef cmp_flags_t: packed struct {eq, gt, lt}.
  - Constant CMP_SEED = '{eq:1, gt:0, lt:0}.
- One sub-module, cmp_slice4:
  - Purely combinational.
  - Inputs: a[3:0], b[3:0], cascade cmp_flags_t.
  - Output: cmp_flags_t.
  - The top generates WIDTH/4 instances, applies signed MSB inversion, and registers the result.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, Eq, Gt, Lt go 0 immediately, without waiting for a clock edge.
- Exhaustive unsigned sweep, WIDTH=4, signed_mode=0: A steps 0..15; for each A, B steps 0..15 with in_valid=1 every cycle. Each result appears 1 cycle later.
  - A=3, B=3 -> Eq=1.
  - A=12, B=5 -> Gt=1.
  - A=0, B=15 -> Lt=1.
  - All 256 pairs match a reference model, one-hot flags.
- Signed mode, WIDTH=4, signed_mode=1:
  - A=4'b1111 (-1), B=4'b0001 -> Lt=1.
  - A=4'b0111, B=4'b1000 -> Gt=1.
  - A=4'b1000, B=4'b1000 -> Eq=1.
  - The same first pair (A=4'b1111, B=4'b0001) with signed_mode=0 -> Gt=1.
- Valid gating: in_valid pattern 1,0,1 with A=5/B=9, then X, then A=9/B=5 -> out_valid 1,0,1; flags Lt, held, Gt.
- Width scaling, WIDTH=12:
  - A=12'h800, B=12'h7FF, unsigned -> Gt=1; signed -> Lt=1.
  - A=B=12'hABC -> Eq=1. This exercises the cascade across all three slices.
- Reset mid-stream: drive in_valid=1 with A=2, B=1, pulse rst_n low before the next edge -> no out_valid for that sample. After release, the first valid A=1, B=2 -> out_valid=1, Lt=1.

Source files
------------

// File: rtl/week03_pkg.sv
// Shared types for the week-3 comparator datapath: slice width and the
// Eq/Gt/Lt cascade flag bundle passed between comparator slices.
package week03_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  localparam cmp_flags_t CMP_SEED = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};

endpackage

// File: rtl/cmp_slice4.sv
// Combinational 4-bit cascadable magnitude compare slice.
// An upstream (more significant) non-equal decision passes through untouched.
module cmp_slice4
  import week03_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  cmp_flags_t         casc_i,
  output cmp_flags_t         flags_o
);

  always_comb begin
    flags_o = casc_i;
    if (casc_i.eq) begin
      flags_o.eq = (a == b);
      flags_o.gt = (a > b);
      flags_o.lt = (a < b);
    end
  end

endmodule

// File: rtl/week0303_mag_comparator.sv
// Registered magnitude comparator built from chained 4-bit slices.
// Signed mode flips both operand MSBs so the unsigned chain orders two's complement.
module week0303_mag_comparator
  import week03_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             Eq,
  output logic             Gt,
  output logic             Lt
);

  localparam int NSLICE = WIDTH / SLICE_W;

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("week0303_mag_comparator: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  logic [WIDTH-1:0] w_msb_flip;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  cmp_flags_t       w_casc [NSLICE:0];
  cmp_flags_t       r_flags;
  logic             r_vld;

  assign w_msb_flip     = {signed_mode, {(WIDTH-1){1'b0}}};
  assign w_a            = A ^ w_msb_flip;
  assign w_b            = B ^ w_msb_flip;
  assign w_casc[NSLICE] = CMP_SEED;

  // Slice NSLICE-1 holds the MSBs and is fed the seed; decisions ripple down.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      cmp_slice4 u_slice (
        .a       (w_a[gi*SLICE_W +: SLICE_W]),
        .b       (w_b[gi*SLICE_W +: SLICE_W]),
        .casc_i  (w_casc[gi+1]),
        .flags_o (w_casc[gi])
      );
    end
  endgenerate

  // Flags load only on a qualified sample, so idle-cycle X/Z never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_flags <= '0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) r_flags <= w_casc[0];
    end
  end

  assign out_valid = r_vld;
  assign Eq        = r_flags.eq;
  assign Gt        = r_flags.gt;
  assign Lt        = r_flags.lt;

endmodule

// File: tb/tb_week0303_mag_comparator.sv
// Scoreboard bench: drivers push expected {Eq,Gt,Lt} plus arrival cycle,
// per-instance monitors pop and compare whenever out_valid is seen.
module tb_week0303_mag_comparator;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [2:0] f;
    int         c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        v12 = 1'b0, sm12 = 1'b0;
  logic [11:0] a12 = '0, b12 = '0;
  logic        ov4, eq4, gt4, lt4;
  logic        ov12, eq12, gt12, lt12;

  exp_t q4[$];
  exp_t q12[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  week0303_mag_comparator #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .signed_mode(sm4),
    .A(a4), .B(b4), .out_valid(ov4), .Eq(eq4), .Gt(gt4), .Lt(lt4)
  );

  week0303_mag_comparator #(.WIDTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(v12), .signed_mode(sm12),
    .A(a12), .B(b12), .out_valid(ov12), .Eq(eq12), .Gt(gt12), .Lt(lt12)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [2:0] ref4(input logic sm, input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (sm) begin
      if (a[3]) ia = ia - 16;
      if (b[3]) ib = ib - 16;
    end
    return (ia == ib) ? EQ : (ia > ib) ? GT : LT;
  endfunction

  task automatic drv4(input logic v, input logic sm, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] e, input bit push = 1'b1);
    exp_t x;
    @(posedge clk);
    #1;
    v4 = v; sm4 = sm; a4 = a; b4 = b;
    if (v && push) begin
      x.f = e; x.c = cyc + 1;
      q4.push_back(x);
    end
  endtask

  task automatic drv12(input logic v, input logic sm, input logic [11:0] a, input logic [11:0] b,
                       input logic [2:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    v12 = v; sm12 = sm; a12 = a; b12 = b;
    if (v) begin
      x.f = e; x.c = cyc + 1;
      q12.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov4) begin
      if (q4.size() == 0) chk("w4_unexpected_valid", 1, 0);
      else begin
        e = q4.pop_front();
        chk("w4_flags", int'({eq4, gt4, lt4}), int'(e.f));
        chk("w4_latency_cycle", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov12) begin
      if (q12.size() == 0) chk("w12_unexpected_valid", 1, 0);
      else begin
        e = q12.pop_front();
        chk("w12_flags", int'({eq12, gt12, lt12}), int'(e.f));
        chk("w12_latency_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_w4_outs", int'({ov4, eq4, gt4, lt4}), 0);
    chk("reset_w12_outs", int'({ov12, eq12, gt12, lt12}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // directed unsigned, then async reset while out_valid is high
    drv4(1, 0, 4'd3, 4'd3, EQ);
    drv4(1, 0, 4'd12, 4'd5, GT);
    drv4(1, 0, 4'd0, 4'd15, LT);
    drv4(0, 0, 4'd0, 4'd0, EQ);
    @(negedge clk);
    #2;
    chk("pre_reset_out_valid", int'(ov4), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_w4_outs", int'({ov4, eq4, gt4, lt4}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // exhaustive unsigned sweep, back-to-back
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drv4(1, 0, 4'(a), 4'(b), ref4(1'b0, 4'(a), 4'(b)));
    drv4(0, 0, 4'd0, 4'd0, EQ);

    // signed mode
    drv4(1, 1, 4'b1111, 4'b0001, LT);
    drv4(1, 1, 4'b0111, 4'b1000, GT);
    drv4(1, 1, 4'b1000, 4'b1000, EQ);
    drv4(1, 0, 4'b1111, 4'b0001, GT);
    drv4(1, 1, 4'b1000, 4'b0111, LT);
    drv4(0, 0, 4'd0, 4'd0, EQ);

    // valid gating with garbage operands in the idle cycle
    drv4(1, 0, 4'd5, 4'd9, LT);
    drv4(0, 0, 4'bxxxx, 4'bxxxx, EQ);
    drv4(1, 0, 4'd9, 4'd5, GT);
    drv4(0, 0, 4'd0, 4'd0, EQ);

    // 12-bit cascade across three slices
    drv12(1, 0, 12'h800, 12'h7FF, GT);
    drv12(1, 1, 12'h800, 12'h7FF, LT);
    drv12(1, 0, 12'hABC, 12'hABC, EQ);
    drv12(1, 0, 12'hABC, 12'hABD, LT);
    drv12(1, 0, 12'hA00, 12'h9FF, GT);
    drv12(1, 1, 12'hFFF, 12'h000, LT);
    drv12(0, 0, 12'h000, 12'h000, EQ);

    // reset pulse discards a captured-but-unread sample
    drv4(1, 0, 4'd2, 4'd1, GT, 1'b0);
    @(posedge clk);
    #1 v4 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midstream_reset_out_valid", int'(ov4), 0);
    rst_n = 1'b1;
    drv4(1, 0, 4'd1, 4'd2, LT);
    drv4(0, 0, 4'd0, 4'd0, EQ);

    repeat (3) @(posedge clk);
    #2;
    chk("w4_queue_drained", q4.size(), 0);
    chk("w12_queue_drained", q12.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
